i2s_codec_if: RTL and testbench

Serial I2S master that sits between the codec pins and the audio processing path. It generates the bit clock (bclk) and word select (lrck), and shifts the parallel 32-bit DAC word out on sdout. It also deserialises sdin into the 32-bit adc_data word consumed by the filter top. It is the pin-side end of the adc_data/dac_data interface.

---
 rtl/i2s_codec_if.sv | 100 ++++++++++
 tb/tb_i2s_codec_if.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_codec_if.sv
// I2S master: generates bclk/lrck, shifts the DAC word out on sdout (duplicated to both
// channels) and deserialises the left-channel ADC word from sdin.
module i2s_codec_if #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_BITS-1:0] dac_data,
    output logic [WORD_BITS-1:0] adc_data,
    output logic                 adc_valid,
    output logic                 bclk,
    output logic                 lrck,
    output logic                 sdout,
    input  logic                 sdin
);

    localparam int HCW = $clog2(CLK_DIV);
    localparam int SLW = $clog2(2 * WORD_BITS);
    localparam logic [HCW-1:0] HC_TC     = HCW'(CLK_DIV - 1);
    localparam logic [SLW-1:0] SLOT_LAST = SLW'(2 * WORD_BITS - 1);
    localparam logic [SLW-1:0] SLOT_LMSB = SLW'(WORD_BITS - 1);
    localparam logic [SLW-1:0] SLOT_RGT  = SLW'(WORD_BITS);
    localparam logic [SLW-1:0] SLOT_RLSB = SLW'(2 * WORD_BITS - 2);

    logic [HCW-1:0]       hc;
    logic [SLW-1:0]       slot;
    logic [SLW-1:0]       slot_nxt;
    logic [WORD_BITS-1:0] tx_shift;
    logic [WORD_BITS-1:0] hold;
    logic [WORD_BITS-1:0] rx_shift;
    logic [WORD_BITS-1:0] rx_word;
    logic [1:0]           sync;
    logic                 sdin_s;
    logic                 hc_tc;
    logic                 rise;
    logic                 fall;
    logic                 lrck_nxt;

    assign hc_tc    = (hc == HC_TC);
    assign rise     = hc_tc && !bclk;
    assign fall     = hc_tc && bclk;
    assign slot_nxt = slot + 1'b1;
    assign sdin_s   = sync[1];
    assign rx_word  = {rx_shift[WORD_BITS-2:0], sdin_s};
    // lrck leads the data by one bit: high from the last left slot to the second-last right slot
    assign lrck_nxt = (slot_nxt >= SLOT_LMSB) && (slot_nxt <= SLOT_RLSB);

    always_ff @(posedge clk) begin
        if (reset) begin
            hc        <= '0;
            bclk      <= 1'b0;
            slot      <= SLOT_LAST;
            lrck      <= 1'b0;
            sdout     <= 1'b0;
            tx_shift  <= '0;
            hold      <= '0;
            rx_shift  <= '0;
            sync      <= '0;
            adc_data  <= '0;
            adc_valid <= 1'b0;
        end else begin
            adc_valid <= 1'b0;
            sync      <= {sync[0], sdin};

            if (hc_tc) begin
                hc   <= '0;
                bclk <= ~bclk;
            end else begin
                hc <= hc + 1'b1;
            end

            if (rise) begin
                rx_shift <= rx_word;
                if (slot == SLOT_LMSB) begin
                    adc_data  <= rx_word;
                    adc_valid <= 1'b1;
                end
            end

            if (fall) begin
                slot <= slot_nxt;
                lrck <= lrck_nxt;
                if (slot_nxt == '0) begin
                    hold     <= dac_data;
                    tx_shift <= dac_data;
                    sdout    <= dac_data[WORD_BITS-1];
                end else if (slot_nxt == SLOT_RGT) begin
                    // right slot replays the held left word
                    tx_shift <= hold;
                    sdout    <= hold[WORD_BITS-1];
                end else begin
                    tx_shift <= tx_shift << 1;
                    sdout    <= tx_shift[WORD_BITS-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_codec_if.sv
// Scoreboard bench for i2s_codec_if: stimulus pushes expected TX/RX words, a negedge
// monitor tracks the slot from bclk, models the codec and checks pins against the queues.
module tb_i2s_codec_if;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dac_data;
    logic [31:0] adc_data;
    logic        adc_valid;
    logic        bclk;
    logic        lrck;
    logic        sdout;
    logic        sdin;

    logic        loop;
    logic        codec_bit;
    logic [31:0] codec_l;
    logic [31:0] codec_r;

    int errors = 0;
    int checks = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic        rx_strict;

    logic [5:0]  tb_slot = 6'd63;
    logic [31:0] cur_tx;
    logic        tx_chk = 1'b0;
    logic        bclk_q = 1'b0;
    logic        lrck_q = 1'b0;
    logic        vld_q = 1'b0;
    int          cyc = 0;
    int          last_rise, last_lr, last_v;
    logic        have_rise = 1'b0;
    logic        have_lr = 1'b0;
    logic        have_v = 1'b0;

    assign sdin = loop ? sdout : codec_bit;

    always #5 clk = ~clk;

    i2s_codec_if #(.CLK_DIV(CLK_DIV), .WORD_BITS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .dac_data  (dac_data),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .bclk      (bclk),
        .lrck      (lrck),
        .sdout     (sdout),
        .sdin      (sdin)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: slot tracking, codec model, pin checks and scoreboard pops
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            tb_slot   = 6'd63;
            tx_chk    = 1'b0;
            have_rise = 1'b0;
            have_lr   = 1'b0;
            have_v    = 1'b0;
        end else begin
            if (bclk && !bclk_q) begin
                if (have_rise) check("bclk_period", cyc - last_rise, 2 * CLK_DIV);
                have_rise = 1'b1;
                last_rise = cyc;
            end
            if (!bclk && bclk_q) begin
                int s;
                tb_slot   = tb_slot + 6'd1;
                s         = int'(tb_slot);
                codec_bit = (s < 32) ? codec_l[31 - s] : codec_r[63 - s];
                check("lrck_slot", {31'd0, lrck}, (s >= 31 && s <= 62) ? 32'd1 : 32'd0);
                if (s == 0) begin
                    if (tx_q.size() > 0) begin
                        cur_tx = tx_q.pop_front();
                        tx_chk = 1'b1;
                    end else begin
                        tx_chk = 1'b0;
                    end
                end
                if (tx_chk)
                    check("sdout_bit", {31'd0, sdout}, {31'd0, cur_tx[(s < 32) ? (31 - s) : (63 - s)]});
            end
            if (lrck && !lrck_q) begin
                if (have_lr) check("frame_period", cyc - last_lr, 128 * CLK_DIV);
                have_lr = 1'b1;
                last_lr = cyc;
            end
            if (adc_valid) begin
                if (vld_q) check("adc_valid_width", {31'd0, vld_q}, 32'd0);
                if (have_v) check("valid_interval", cyc - last_v, 128 * CLK_DIV);
                have_v = 1'b1;
                last_v = cyc;
                if (rx_q.size() > 0) check("adc_data", adc_data, rx_q.pop_front());
                else if (rx_strict) check("unexpected_valid", {31'd0, adc_valid}, 32'd0);
            end
        end
        bclk_q = bclk;
        lrck_q = lrck;
        vld_q  = adc_valid;
    end

    // returns just after the posedge following the next entry into slot target
    task automatic wait_slot(input logic [5:0] target);
        logic armed = 1'b0;
        logic found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk);
            if (tb_slot != target) armed = 1'b1;
            else if (armed) found = 1'b1;
        end
        if (!found) check("wait_slot_timeout", {26'd0, tb_slot}, {26'd0, target});
        #2;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        dac_data  = 32'd0;
        loop      = 1'b0;
        codec_l   = 32'd0;
        codec_r   = 32'd0;
        codec_bit = 1'b0;
        rx_strict = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // transmit: word latched at slot 0, mid-frame change deferred to next frame
        wait_slot(6'd40);
        dac_data = 32'hA5C3_0F81;
        tx_q.push_back(32'hA5C3_0F81);
        wait_slot(6'd5);
        dac_data = 32'h1234_5678;
        tx_q.push_back(32'h1234_5678);

        // receive from codec model for two frames
        wait_slot(6'd40);
        codec_l = 32'hDEAD_BEEF;
        codec_r = 32'h0000_0000;
        rx_q.push_back(32'hDEAD_BEEF);
        rx_q.push_back(32'hDEAD_BEEF);
        rx_strict = 1'b1;
        wait_slot(6'd40);
        wait_slot(6'd40);

        // loopback
        loop     = 1'b1;
        dac_data = 32'h8000_0001;
        tx_q.push_back(32'h8000_0001);
        tx_q.push_back(32'h8000_0001);
        rx_q.push_back(32'h8000_0001);
        rx_q.push_back(32'h8000_0001);
        wait_slot(6'd40);
        wait_slot(6'd40);
        loop    = 1'b0;
        codec_l = 32'h1357_9BDF;

        // reset during slot 20 of a receive
        wait_slot(6'd20);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_bclk", {31'd0, bclk}, 32'd0);
        check("rst_lrck", {31'd0, lrck}, 32'd0);
        check("rst_sdout", {31'd0, sdout}, 32'd0);
        check("rst_adc_valid", {31'd0, adc_valid}, 32'd0);
        check("rst_adc_data", adc_data, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (bclk) break;
        end
        check("first_rise_delay", n, CLK_DIV);

        wait_slot(6'd10);
        check("adc_data_after_reset", adc_data, 32'd0);
        rx_q.push_back(32'h1357_9BDF);
        for (int i = 0; i < 1000 && rx_q.size() > 0; i++) @(posedge clk);
        wait_slot(6'd40);
        check("rx_q_drained", rx_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
